// File: rtl/matmul_apb_slave_if.sv
// APB bus bundle between the matmul register slave and its bus master.
interface matmul_apb_slave_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned BUS_WIDTH  = 64
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [BUS_WIDTH-1:0]  pwdata;
   logic [BUS_WIDTH-1:0]  prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/matmul_apb_slave.sv
// APB register slave for the matmul engine: CONTROL/STATUS registers plus row windows onto
// operand A, operand B and the result scratchpad. Every transfer takes exactly
// setup + access + one response cycle; pready/pslverr/prdata are registered.
module matmul_apb_slave #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned BUS_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned SP_NTARGETS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   matmul_apb_slave_if.slave    apb,
   output logic                 busy,
   output logic                 start,
   input  logic                 done,
   output logic [1:0]           mem_sel,
   output logic [7:0]           mem_idx,
   output logic                 mem_we,
   output logic                 mem_re,
   output logic [BUS_WIDTH-1:0] mem_wdata,
   input  logic [BUS_WIDTH-1:0] mem_rdata
);
   localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int unsigned SP_ROWS = SP_NTARGETS * MAX_DIM;
   localparam int unsigned PW      = ADDR_WIDTH - 8;

   localparam logic [PW-1:0] PAGE_REG = PW'(0);
   localparam logic [PW-1:0] PAGE_A   = PW'(1);
   localparam logic [PW-1:0] PAGE_B   = PW'(2);
   localparam logic [PW-1:0] PAGE_SP  = PW'(3);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t               state_q;
   logic                 write_q, err_q, mem_q, ctrl_q, stat_q;
   logic [1:0]           sel_q;
   logic [7:0]           idx_q;
   logic [BUS_WIDTH-1:0] wdata_q, prdata_q;
   logic                 pready_q, pslverr_q, mem_we_q, start_q, busy_q, done_sticky_q;

   logic [PW-1:0]        page;
   logic [4:0]           row;
   logic [31:0]          row_ext;
   logic [1:0]           dec_sel;
   logic [7:0]           dec_idx;
   logic                 dec_mem, dec_ctrl, dec_stat, dec_err;
   logic                 setup;
   logic [BUS_WIDTH-1:0] status;

   assign page    = apb.paddr[ADDR_WIDTH-1:8];
   assign row     = apb.paddr[7:3];
   assign row_ext = {27'd0, row};

   // Decode the address presented in the setup cycle and classify it as legal or an error.
   always_comb begin
      dec_sel  = 2'd0;
      dec_idx  = 8'd0;
      dec_mem  = 1'b0;
      dec_ctrl = 1'b0;
      dec_stat = 1'b0;
      dec_err  = 1'b0;
      if (apb.paddr[2:0] != 3'd0) begin
         dec_err = 1'b1;
      end else if (page == PAGE_REG) begin
         if (apb.paddr[7:0] == 8'h00) begin
            dec_ctrl = 1'b1;
            dec_err  = apb.pwrite && busy_q;
         end else if (apb.paddr[7:0] == 8'h08) begin
            dec_stat = 1'b1;
            dec_err  = apb.pwrite;
         end else begin
            dec_err = 1'b1;
         end
      end else if (page == PAGE_A || page == PAGE_B) begin
         dec_sel = (page == PAGE_A) ? 2'd0 : 2'd1;
         dec_idx = {3'd0, row};
         dec_mem = 1'b1;
         dec_err = (row_ext >= MAX_DIM) || (apb.pwrite && busy_q);
      end else if (page == PAGE_SP) begin
         dec_sel = 2'd2;
         dec_idx = {3'd0, row};
         dec_mem = 1'b1;
         dec_err = (row_ext >= SP_ROWS) || apb.pwrite;
      end else begin
         dec_err = 1'b1;
      end
   end

   // STATUS word as seen by a read.
   always_comb begin
      status      = '0;
      status[1:0] = {done_sticky_q, busy_q};
   end

   // Transfer FSM with engine handshake; all bus and engine outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         write_q       <= 1'b0;
         err_q         <= 1'b0;
         mem_q         <= 1'b0;
         ctrl_q        <= 1'b0;
         stat_q        <= 1'b0;
         sel_q         <= 2'd0;
         idx_q         <= 8'd0;
         wdata_q       <= '0;
         prdata_q      <= '0;
         pready_q      <= 1'b0;
         pslverr_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         start_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_sticky_q <= 1'b0;
      end else begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         mem_we_q  <= 1'b0;
         start_q   <= 1'b0;
         if (done && busy_q) begin
            busy_q        <= 1'b0;
            done_sticky_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (apb.psel) begin
                  write_q <= apb.pwrite;
                  err_q   <= dec_err;
                  mem_q   <= dec_mem;
                  ctrl_q  <= dec_ctrl;
                  stat_q  <= dec_stat;
                  sel_q   <= dec_sel;
                  idx_q   <= dec_idx;
                  wdata_q <= apb.pwdata;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!apb.psel) begin
                  state_q <= IDLE;
               end else if (apb.penable) begin
                  state_q   <= RESP;
                  pready_q  <= 1'b1;
                  pslverr_q <= err_q;
                  mem_we_q  <= !err_q && write_q && mem_q;
                  if (!err_q && !write_q) begin
                     if (mem_q) begin
                        prdata_q <= mem_rdata;
                     end else if (stat_q) begin
                        prdata_q <= status;
                     end
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               // Start commits after the response; error already covers the busy case.
               if (!err_q && write_q && ctrl_q && wdata_q[0]) begin
                  busy_q        <= 1'b1;
                  start_q       <= 1'b1;
                  done_sticky_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory address/read strobe come straight from the bus in the setup cycle, then from
   // the captured copy, so the target is stable from setup until the response ends.
   assign setup       = rst && (state_q == IDLE) && apb.psel;
   assign mem_sel     = setup ? dec_sel : sel_q;
   assign mem_idx     = setup ? dec_idx : idx_q;
   assign mem_re      = setup && dec_mem && !dec_err && !apb.pwrite;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = wdata_q;
   assign busy        = busy_q;
   assign start       = start_q;
   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed and randomized APB transfers checked
// against a register/memory model of the address map and engine handshake.
module tb_matmul_apb_slave;
   localparam int MAX_DIM = 4;
   localparam int SP_ROWS = 16;

   logic        clk;
   logic        rst;
   logic        busy, start, done;
   logic [1:0]  mem_sel;
   logic [7:0]  mem_idx;
   logic        mem_we, mem_re;
   logic [63:0] mem_wdata, mem_rdata;

   matmul_apb_slave_if #(.ADDR_WIDTH(16), .BUS_WIDTH(64)) apb ();

   matmul_apb_slave dut (
      .clk       (clk),
      .rst       (rst),
      .apb       (apb),
      .busy      (busy),
      .start     (start),
      .done      (done),
      .mem_sel   (mem_sel),
      .mem_idx   (mem_idx),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External memories the slave fronts.
   logic [63:0] env_a  [256] = '{default: '0};
   logic [63:0] env_b  [256] = '{default: '0};
   logic [63:0] env_sp [256];

   always @(posedge clk) begin
      if (mem_we && mem_sel == 2'd0) env_a[mem_idx] <= mem_wdata;
      if (mem_we && mem_sel == 2'd1) env_b[mem_idx] <= mem_wdata;
      if (mem_re) begin
         mem_rdata <= (mem_sel == 2'd0) ? env_a[mem_idx] :
                      (mem_sel == 2'd1) ? env_b[mem_idx] : env_sp[mem_idx];
      end
   end

   // Bus/engine event monitor, sampled on the falling edge.
   int          we_count = 0, pready_count = 0, viol = 0;
   logic [1:0]  we_sel;
   logic [7:0]  we_idx;
   logic [63:0] we_data;
   logic        prev_pready = 1'b0;

   always @(negedge clk) begin
      if (mem_we) begin
         we_count <= we_count + 1;
         we_sel   <= mem_sel;
         we_idx   <= mem_idx;
         we_data  <= mem_wdata;
      end
      if (apb.pready) pready_count <= pready_count + 1;
      if (apb.pready && prev_pready) viol <= viol + 1;
      if (apb.pslverr && !apb.pready) viol <= viol + 1;
      prev_pready <= apb.pready;
   end

   // Reference model of the register map.
   logic [63:0] m_a [MAX_DIM];
   logic [63:0] m_b [MAX_DIM];
   logic [63:0] m_sp [SP_ROWS];
   logic        busy_m = 1'b0, sticky_m = 1'b0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic wr, input int addr);
      if (addr % 8 != 0) return 1'b1;
      if (addr == 0) return wr && busy_m;
      if (addr == 8) return wr;
      if (addr >= 'h100 && addr < 'h100 + 8 * MAX_DIM) return wr && busy_m;
      if (addr >= 'h200 && addr < 'h200 + 8 * MAX_DIM) return wr && busy_m;
      if (addr >= 'h300 && addr < 'h300 + 8 * SP_ROWS) return wr;
      return 1'b1;
   endfunction

   function automatic logic [63:0] model_read(input int addr);
      if (addr == 8) return {62'd0, sticky_m, busy_m};
      if (addr >= 'h300) return m_sp[(addr - 'h300) / 8];
      if (addr >= 'h200) return m_b[(addr - 'h200) / 8];
      if (addr >= 'h100) return m_a[(addr - 'h100) / 8];
      return 64'd0;
   endfunction

   // One APB transfer starting just after a rising edge; returns one cycle after pready.
   task automatic xfer(input logic wr, input logic [15:0] addr, input logic [63:0] wd,
                       input logic pulse_done, output logic [63:0] rd, output logic err,
                       output int lat);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wd;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!apb.pready && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      done = pulse_done;
      rd = apb.prdata;
      err = apb.pslverr;
      apb.psel = 1'b0; apb.penable = 1'b0;
      @(posedge clk); #1;
      done = 1'b0;
   endtask

   // Transfer plus model prediction of error, read data, write strobe, start and busy.
   task automatic run(input logic wr, input int addr, input logic [63:0] wd,
                      input logic pulse_done, input string tag);
      logic [63:0] rd, exp_rd;
      logic        err, exp_err, exp_we, exp_st;
      int          lat, we0;
      exp_err = model_err(wr, addr);
      exp_rd  = (wr || exp_err) ? 64'd0 : model_read(addr);
      exp_we  = wr && !exp_err && addr >= 'h100 && addr < 'h300;
      exp_st  = wr && !exp_err && addr == 0 && wd[0];
      we0 = we_count;
      xfer(wr, 16'(addr), wd, pulse_done, rd, err, lat);
      if (exp_we && addr < 'h200) m_a[(addr - 'h100) / 8] = wd;
      if (exp_we && addr >= 'h200) m_b[(addr - 'h200) / 8] = wd;
      if (pulse_done && busy_m) begin
         busy_m = 1'b0;
         sticky_m = 1'b1;
      end
      if (exp_st) begin
         busy_m = 1'b1;
         sticky_m = 1'b0;
      end
      chk({tag, "/pslverr"}, 64'(err), 64'(exp_err));
      chk({tag, "/prdata"}, rd, exp_rd);
      chk({tag, "/latency"}, 64'(lat), 64'd1);
      chk({tag, "/mem_we"}, 64'(we_count - we0), 64'(exp_we));
      chk({tag, "/start"}, 64'(start), 64'(exp_st));
      chk({tag, "/busy"}, 64'(busy), 64'(busy_m));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/prdata"}, apb.prdata, 64'd0);
      chk({tag, "/mem_wdata"}, mem_wdata, 64'd0);
      chk({tag, "/ctl"}, 64'({apb.pready, apb.pslverr, busy, start, mem_we, mem_re,
                              mem_sel, mem_idx}), 64'd0);
   endtask

   initial begin
      int          addr, we0, pr0;
      logic [63:0] wd;
      rst = 1'b0; done = 1'b0;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 16'h0108;
      apb.pwdata = '0;
      for (int i = 0; i < 256; i++) env_sp[i] = {$urandom, $urandom};
      for (int i = 0; i < SP_ROWS; i++) m_sp[i] = env_sp[i];
      for (int i = 0; i < MAX_DIM; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      apb.psel = 1'b0;
      rst = 1'b1;

      // Operand row write/readback.
      run(1'b1, 'h108, 64'h1111_2222_3333_4444, 1'b0, "a1_wr");
      chk("a1_wr/sel", 64'(we_sel), 64'd0);
      chk("a1_wr/idx", 64'(we_idx), 64'd1);
      chk("a1_wr/wdata", we_data, 64'h1111_2222_3333_4444);
      run(1'b0, 'h108, 64'd0, 1'b0, "a1_rd");

      // Error cases.
      run(1'b0, 'h104, 64'd0, 1'b0, "unaligned");
      run(1'b0, 'h400, 64'd0, 1'b0, "unmapped");
      run(1'b1, 'h300, 64'h5, 1'b0, "sp_wr");
      run(1'b1, 'h008, 64'h3, 1'b0, "status_wr");
      run(1'b0, 'h120, 64'd0, 1'b0, "a_row_oob");
      run(1'b0, 'h380, 64'd0, 1'b0, "sp_row_oob");
      run(1'b0, 'h378, 64'd0, 1'b0, "sp_last");
      run(1'b0, 'h008, 64'd0, 1'b0, "status0");

      // Randomized traffic across the map while the engine is idle.
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: addr = 8 * $urandom_range(0, 2);
            1: addr = 'h100 + 8 * $urandom_range(0, 4);
            2: addr = 'h200 + 8 * $urandom_range(0, 4);
            3: addr = 'h300 + 8 * $urandom_range(0, 16);
            default: addr = 8 * $urandom_range(0, 127);
         endcase
         if ($urandom_range(0, 7) == 0) addr += 4;
         wd = {$urandom, $urandom};
         if (addr == 0) wd[0] = 1'b0;
         run(1'(($urandom_range(0, 1))), addr, wd, 1'b0, "rand");
      end

      // Engine start / busy / done handshake.
      run(1'b1, 'h000, 64'd1, 1'b0, "start1");
      @(posedge clk); #1;
      chk("start1/pulse_width", 64'(start), 64'd0);
      run(1'b1, 'h000, 64'd1, 1'b0, "start_busy");
      run(1'b1, 'h110, {$urandom, $urandom}, 1'b0, "a_wr_busy");
      run(1'b0, 'h108, 64'd0, 1'b0, "a_rd_busy");
      run(1'b0, 'h008, 64'd0, 1'b0, "status_busy");
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      busy_m = 1'b0; sticky_m = 1'b1;
      chk("done/busy", 64'(busy), 64'd0);
      run(1'b0, 'h008, 64'd0, 1'b0, "status_done");
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      chk("done_idle/busy", 64'(busy), 64'd0);
      run(1'b0, 'h008, 64'd0, 1'b0, "status_idle_done");
      run(1'b1, 'h000, 64'd0, 1'b0, "ctrl_zero");
      run(1'b1, 'h000, 64'd1, 1'b0, "start2");
      run(1'b0, 'h008, 64'd0, 1'b0, "status_start2");
      run(1'b1, 'h000, 64'd1, 1'b1, "start_vs_done");
      run(1'b0, 'h008, 64'd0, 1'b0, "status_after_race");

      // Abort in the access phase.
      we0 = we_count; pr0 = pready_count;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 16'h0110;
      apb.pwdata = {$urandom, $urandom};
      @(posedge clk); #1;
      apb.psel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort/pready", 64'(pready_count - pr0), 64'd0);
      chk("abort/mem_we", 64'(we_count - we0), 64'd0);
      run(1'b0, 'h110, 64'd0, 1'b0, "after_abort");

      // Asynchronous reset during the access cycle of a write.
      run(1'b1, 'h000, 64'd1, 1'b0, "start3");
      we0 = we_count;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 16'h0118;
      apb.pwdata = 64'hDEAD_BEEF_0BAD_F00D;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk_zero("async_rst");
      apb.psel = 1'b0; apb.penable = 1'b0;
      @(posedge clk); #1;
      chk("async_rst/mem_we", 64'(we_count - we0), 64'd0);
      busy_m = 1'b0; sticky_m = 1'b0;
      rst = 1'b1;
      run(1'b0, 'h118, 64'd0, 1'b0, "after_rst");
      run(1'b0, 'h008, 64'd0, 1'b0, "status_after_rst");

      chk("pready_protocol", 64'(viol), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
